fht_but_pipe: RTL and testbench

FHT_BUT_PIPE -- requirements
Module: fht_but_pipe

---
 rtl/fht_pkg.sv | 26 ++
 rtl/fht_but_pipe_if.sv | 34 +++
 rtl/fht_sat.sv | 43 ++++
 rtl/fht_but_pipe.sv | 115 +++++++++++
 tb/tb_fht_but_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fht_pkg.sv
// Shared sizing defaults, the twiddle-product rounding offset and saturation bounds
// used by the FHT butterfly pipeline and its saturation stage.
package fht_pkg;

   localparam int D_SIZE_DEF = 16;
   localparam int W_SIZE_DEF = 16;

   typedef enum logic {
      MODE_UNSCALED = 1'b0,
      MODE_SCALED   = 1'b1
   } scale_mode_t;

   // Half an LSB of the Q1.(w-1) product, added before the truncating shift
   function automatic longint round_offset(input int w);
      return longint'(1) <<< (w - 2);
   endfunction

   function automatic longint sat_max(input int d);
      return (longint'(1) <<< (d - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int d);
      return -(longint'(1) <<< (d - 1));
   endfunction

endpackage

// File: rtl/fht_but_pipe_if.sv
// Sample stream into and out of the FHT butterfly: operands, twiddles, mode bit,
// valid/ready handshake on both sides and the saturated results.
interface fht_but_pipe_if
   import fht_pkg::*;
#(
   parameter int D_SIZE = D_SIZE_DEF,
   parameter int W_SIZE = W_SIZE_DEF
);

   logic                     iVALID;
   logic                     oREADY;
   logic signed [D_SIZE-1:0] iX_0;
   logic signed [D_SIZE-1:0] iX_1;
   logic signed [D_SIZE-1:0] iX_2;
   logic signed [W_SIZE-1:0] iSIN;
   logic signed [W_SIZE-1:0] iCOS;
   logic                     iSCALE;
   logic                     oVALID;
   logic                     iREADY;
   logic signed [D_SIZE-1:0] oY_0;
   logic signed [D_SIZE-1:0] oY_1;
   logic                     oOVF;

   modport slave (
      input  iVALID, iX_0, iX_1, iX_2, iSIN, iCOS, iSCALE, iREADY,
      output oREADY, oVALID, oY_0, oY_1, oOVF
   );

   modport master (
      output iVALID, iX_0, iX_1, iX_2, iSIN, iCOS, iSCALE, iREADY,
      input  oREADY, oVALID, oY_0, oY_1, oOVF
   );

endinterface

// File: rtl/fht_sat.sv
// Optional round-half-up halving of a wide butterfly sum, then clipping to an
// OW-bit signed result with a flag that reports the clip.
module fht_sat
   import fht_pkg::*;
#(
   parameter int IW = 19,
   parameter int OW = 16
) (
   input  logic signed [IW-1:0] a,
   input  logic                 halve,
   output logic signed [OW-1:0] y,
   output logic                 clip
);

   localparam int EW = IW + 1;
   localparam logic signed [EW-1:0] HI = EW'(sat_max(OW));
   localparam logic signed [EW-1:0] LO = EW'(sat_min(OW));

   logic signed [EW-1:0] ax;
   logic signed [EW-1:0] h;

   assign ax = EW'(a);

   // One extra bit keeps the +1 of the rounding from wrapping before the shift
   always_comb begin
      h    = ax;
      y    = '0;
      clip = 1'b0;
      if (halve) begin
         h = (ax + EW'(1)) >>> 1;
      end
      if (h > HI) begin
         y    = OW'(HI);
         clip = 1'b1;
      end else if (h < LO) begin
         y    = OW'(LO);
         clip = 1'b1;
      end else begin
         y    = OW'(h);
      end
   end

endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage FHT butterfly: twiddle products, rounded sum, then add/subtract with
// optional halving and saturation, under a single stall-everything enable.
module fht_but_pipe
   import fht_pkg::*;
#(
   parameter int D_SIZE = D_SIZE_DEF,
   parameter int W_SIZE = W_SIZE_DEF
) (
   input logic            iCLK,
   input logic            iRESET,
   fht_but_pipe_if.slave  bus
);

   localparam int PW = D_SIZE + W_SIZE;
   localparam int SW = PW + 1;
   localparam int TW = D_SIZE + 2;
   localparam int AW = D_SIZE + 3;
   localparam logic signed [SW-1:0] RND = SW'(round_offset(W_SIZE));

   logic en;

   logic                     v1;
   logic signed [PW-1:0]     c1;
   logic signed [PW-1:0]     s1;
   logic signed [D_SIZE-1:0] x0_1;
   scale_mode_t              m1;

   logic                     v2;
   logic signed [TW-1:0]     t2;
   logic signed [D_SIZE-1:0] x0_2;
   scale_mode_t              m2;

   logic signed [SW-1:0]     sum2;
   logic signed [AW-1:0]     a0;
   logic signed [AW-1:0]     a1;
   logic signed [D_SIZE-1:0] y0n;
   logic signed [D_SIZE-1:0] y1n;
   logic                     clip0;
   logic                     clip1;

   // The whole pipe freezes only when a finished sample is waiting on downstream
   assign en         = !bus.oVALID || bus.iREADY;
   assign bus.oREADY = en;

   // Products are kept at full width so a -1.0 twiddle stays exact
   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         v1   <= 1'b0;
         c1   <= '0;
         s1   <= '0;
         x0_1 <= '0;
         m1   <= MODE_UNSCALED;
      end else if (en) begin
         v1 <= bus.iVALID;
         if (bus.iVALID) begin
            c1   <= PW'(bus.iCOS) * PW'(bus.iX_1);
            s1   <= PW'(bus.iSIN) * PW'(bus.iX_2);
            x0_1 <= bus.iX_0;
            m1   <= scale_mode_t'(bus.iSCALE);
         end
      end
   end

   assign sum2 = SW'(c1) + SW'(s1) + RND;

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         v2   <= 1'b0;
         t2   <= '0;
         x0_2 <= '0;
         m2   <= MODE_UNSCALED;
      end else if (en) begin
         v2 <= v1;
         if (v1) begin
            t2   <= TW'(sum2 >>> (W_SIZE - 1));
            x0_2 <= x0_1;
            m2   <= m1;
         end
      end
   end

   assign a0 = AW'(x0_2) + AW'(t2);
   assign a1 = AW'(x0_2) - AW'(t2);

   fht_sat #(.IW(AW), .OW(D_SIZE)) u_sat0 (
      .a     (a0),
      .halve (m2 == MODE_SCALED),
      .y     (y0n),
      .clip  (clip0)
   );

   fht_sat #(.IW(AW), .OW(D_SIZE)) u_sat1 (
      .a     (a1),
      .halve (m2 == MODE_SCALED),
      .y     (y1n),
      .clip  (clip1)
   );

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         bus.oVALID <= 1'b0;
         bus.oY_0   <= '0;
         bus.oY_1   <= '0;
         bus.oOVF   <= 1'b0;
      end else if (en) begin
         bus.oVALID <= v2;
         if (v2) begin
            bus.oY_0 <= y0n;
            bus.oY_1 <= y1n;
            bus.oOVF <= clip0 || clip1;
         end
      end
   end

endmodule

// File: tb/tb_fht_but_pipe.sv
// Self-checking bench for the FHT butterfly pipe: directed vectors, a stalled random
// stream scored against a real-arithmetic model, and mid-flight reset.
module tb_fht_but_pipe;

   localparam int D = 16;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rstN;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fht_but_pipe_if #(.D_SIZE(D), .W_SIZE(W)) bus ();

   fht_but_pipe #(.D_SIZE(D), .W_SIZE(W)) dut (
      .iCLK   (clk),
      .iRESET (rstN),
      .bus    (bus)
   );

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int x0, input int x1, input int x2, input int c,
                                input int s, input bit sc, input bit v);
      bus.iX_0   = D'(x0);
      bus.iX_1   = D'(x1);
      bus.iX_2   = D'(x2);
      bus.iCOS   = W'(c);
      bus.iSIN   = W'(s);
      bus.iSCALE = sc;
      bus.iVALID = v;
   endtask

   // Butterfly on real numbers: twiddles are fractions of 1.0, ties round upward
   function automatic void refModel(input int x0, input int x1, input int x2, input int c,
                                    input int s, input bit sc, output int y0,
                                    output int y1, output bit ovf);
      real    t_r;
      longint t;
      longint a [2];
      t_r  = (real'(c) * real'(x1) + real'(s) * real'(x2)) / 32768.0;
      t    = longint'($floor(t_r + 0.5));
      a[0] = longint'(x0) + t;
      a[1] = longint'(x0) - t;
      ovf  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (sc) a[k] = longint'($floor(real'(a[k]) / 2.0 + 0.5));
         if (a[k] > 32767) begin
            a[k] = 32767;
            ovf  = 1'b1;
         end else if (a[k] < -32768) begin
            a[k] = -32768;
            ovf  = 1'b1;
         end
      end
      y0 = int'(a[0]);
      y1 = int'(a[1]);
   endfunction

   function automatic int randData();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic runSingle(input string tag, input int x0, input int x1, input int x2,
                            input int c, input int s, input bit sc,
                            input int ey0, input int ey1, input bit eovf);
      applyStimulus(x0, x1, x2, c, s, sc, 1'b1);
      @(negedge clk);
      applyStimulus(randData(), randData(), randData(), randData(), randData(), 1'b1, 1'b0);
      checkOutput({tag, "_lat1"}, bus.oVALID, 0);
      @(negedge clk);
      checkOutput({tag, "_lat2"}, bus.oVALID, 0);
      @(negedge clk);
      checkOutput({tag, "_valid"}, bus.oVALID, 1);
      checkOutput({tag, "_y0"}, bus.oY_0, ey0);
      checkOutput({tag, "_y1"}, bus.oY_1, ey1);
      checkOutput({tag, "_ovf"}, bus.oOVF, eovf);
      @(negedge clk);
      checkOutput({tag, "_bubble"}, bus.oVALID, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sx0 [10], sx1 [10], sx2 [10], scs [10], ssn [10];
      bit ssc [10];
      int expY0 [$], expY1 [$];
      bit expOvf [$];
      int sent, got, cyc, ey0, ey1, seen;
      bit eovf, wasStalled;
      logic signed [D-1:0] holdY0, holdY1;
      logic holdOvf;

      rstN       = 1'b0;
      bus.iREADY = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", bus.oVALID, 0);
      checkOutput("rst_ready", bus.oREADY, 1);
      checkOutput("rst_y0", bus.oY_0, 0);
      checkOutput("rst_y1", bus.oY_1, 0);
      checkOutput("rst_ovf", bus.oOVF, 0);
      rstN = 1'b1;
      @(negedge clk);

      runSingle("scaled", 100, 200, 50, 16384, 0, 1'b1, 100, 0, 1'b0);
      runSingle("unscaled", 100, 200, 50, 16384, 0, 1'b0, 200, 0, 1'b0);
      runSingle("sat_pos", 32767, 32767, 0, 32767, 0, 1'b0, 32767, 1, 1'b1);
      runSingle("sat_neg", -32768, -32768, -32768, -32768, -32768, 1'b0, 32767, -32768, 1'b1);
      runSingle("round", 1, -1, 0, 16384, 0, 1'b1, 1, 1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         sx0[i] = randData();
         sx1[i] = randData();
         sx2[i] = randData();
         scs[i] = randData();
         ssn[i] = randData();
         ssc[i] = 1'($urandom_range(0, 1));
      end

      // Downstream stalls for cycles 4-7 while the 10 samples stream back-to-back
      sent = 0;
      got = 0;
      cyc = 0;
      wasStalled = 1'b0;
      holdY0 = '0;
      holdY1 = '0;
      holdOvf = 1'b0;
      while (got < 10 && cyc < 80) begin
         bus.iREADY = !(cyc >= 4 && cyc <= 7);
         if (sent < 10)
            applyStimulus(sx0[sent], sx1[sent], sx2[sent], scs[sent], ssn[sent], ssc[sent], 1'b1);
         else
            applyStimulus(randData(), randData(), randData(), randData(), randData(), 1'b0, 1'b0);
         #1;
         if (wasStalled) begin
            checkOutput("stream_hold_y0", bus.oY_0, holdY0);
            checkOutput("stream_hold_y1", bus.oY_1, holdY1);
            checkOutput("stream_hold_ovf", bus.oOVF, holdOvf);
         end
         checkOutput("stream_ready", bus.oREADY, !(bus.oVALID && !bus.iREADY));
         if (bus.oVALID && bus.iREADY) begin
            if (expY0.size() == 0) begin
               checkOutput("stream_extra", 1, 0);
            end else begin
               checkOutput("stream_y0", bus.oY_0, expY0.pop_front());
               checkOutput("stream_y1", bus.oY_1, expY1.pop_front());
               checkOutput("stream_ovf", bus.oOVF, expOvf.pop_front());
            end
            got++;
         end
         wasStalled = bus.oVALID && !bus.iREADY;
         holdY0 = bus.oY_0;
         holdY1 = bus.oY_1;
         holdOvf = bus.oOVF;
         if (sent < 10 && bus.oREADY) begin
            refModel(sx0[sent], sx1[sent], sx2[sent], scs[sent], ssn[sent], ssc[sent],
                     ey0, ey1, eovf);
            expY0.push_back(ey0);
            expY1.push_back(ey1);
            expOvf.push_back(eovf);
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      checkOutput("stream_count", got, 10);
      bus.iREADY = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      // Two samples in flight when reset hits; neither may ever come out
      applyStimulus(1000, 20000, 3000, 30000, 12000, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(-500, 15000, -7000, 25000, -9000, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("midrst_valid", bus.oVALID, 0);
      checkOutput("midrst_y0", bus.oY_0, 0);
      checkOutput("midrst_y1", bus.oY_1, 0);
      checkOutput("midrst_ovf", bus.oOVF, 0);
      checkOutput("midrst_ready", bus.oREADY, 1);
      rstN = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.oVALID) seen++;
      end
      checkOutput("midrst_no_leak", seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
